trace_arbiter: RTL and testbench
================================

TRACE_ARBITER -- requirements
Module: trace_arbiter

Interface
REQ-001 The block SHALL have parameter NSRC, default 5, giving the number of trace sources (4 tiles + NoC).
REQ-002 The block SHALL have parameter Fpay, default 32, giving the trace word width.
REQ-003 The block SHALL have parameter DEPTH, default 4, giving the per-source FIFO depth; it must be a power of 2 and at least 2.
REQ-004 Port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port trace_all, input, NSRC*Fpay bits: source i occupies bits [(i+1)*Fpay-1 : i*Fpay].
REQ-007 Port trigger_all, input, NSRC bits: bit i is a one-cycle write strobe for source i.
REQ-008 Port out_ready, input, 1 bit: the downstream trace buffer accepts a word.
REQ-009 Port clear_ovf, input, 1 bit: synchronous clear of the overflow status.
REQ-010 Port trace_out, output, Fpay bits: the arbitrated trace word.
REQ-011 Port trigger_out, output, 1 bit: trace_out is valid this cycle; this is the write enable of the trace buffer.
REQ-012 Port src_id, output, ceil(log2 NSRC) bits: the source index of trace_out.
REQ-013 Port overflow, output, NSRC bits: sticky per-source drop flags.
REQ-014 Port drop_cnt, output, 16 bits: saturating total count of dropped words.

Function
REQ-015 Each source SHALL have its own FIFO of DEPTH entries with a write pointer, a read pointer and a count of log2(DEPTH)+1 bits; pointers wrap modulo DEPTH.
REQ-016 When trigger_all[i]=1 and FIFO i is not full, trace word i SHALL be written into FIFO i at that clock edge.
REQ-017 When trigger_all[i]=1, FIFO i is full, and FIFO i is granted a pop in the same cycle, the write SHALL be accepted, the count SHALL stay at DEPTH, and no drop SHALL occur.
REQ-018 When trigger_all[i]=1, FIFO i is full, and there is no same-cycle pop of FIFO i:
- the word SHALL be discarded;
- overflow[i] SHALL be set;
- drop_cnt SHALL increment by 1, saturating at 16'hFFFF.
REQ-019 Drops on several sources in the same cycle SHALL add the number of dropping sources to drop_cnt, still saturating at 16'hFFFF.
REQ-020 The arbiter SHALL be round-robin over non-empty FIFOs.
- The priority pointer resets to 0.
- After granting source g, the pointer SHALL become (g+1) mod NSRC.
- With no grant, the pointer SHALL hold.
REQ-021 A grant SHALL occur only in a cycle where out_ready=1 and at least one FIFO is non-empty; exactly one FIFO is popped per grant.
REQ-022 On a grant, the output register SHALL load the FIFO head and the granted index, so that trace_out/src_id are valid with trigger_out=1 in the following cycle.
REQ-023 In a cycle with no grant, trigger_out SHALL be 0 in the next cycle, and trace_out and src_id SHALL hold their previous values.
REQ-024 Latency: a word strobed into an empty FIFO at edge t, with out_ready=1 and no competing source, SHALL appear with trigger_out=1 in the cycle after edge t+1, i.e. 2 cycles after the strobe.
REQ-025 Throughput SHALL be one word per cycle while out_ready=1 and any FIFO is non-empty.
REQ-026 When out_ready=0, no FIFO SHALL be popped; FIFOs keep filling, and overflow handling follows REQ-018.
REQ-027 When clear_ovf=1, overflow and drop_cnt SHALL clear to 0 at the edge; a drop in the same cycle SHALL win, so that bit is set and drop_cnt equals that cycle's drop count.
REQ-028 Words from a single source SHALL leave in the order written; words are never duplicated.

Reset
REQ-029 While reset=0, asynchronously:
- all FIFO pointers and counts SHALL be 0;
- the RR pointer SHALL be 0;
- trigger_out SHALL be 0, and trace_out and src_id SHALL be 0;
- overflow SHALL be 0 and drop_cnt SHALL be 0.
REQ-030 Assertion of reset mid-operation SHALL discard all buffered words; the first trigger_out after release SHALL come only from strobes after release.
REQ-031 FIFO storage arrays need not be reset.

Verification
REQ-032 Single word: out_ready=1; one cycle with trigger_all=5'b00100 and trace_all word 2=32'hDEADBEEF -> exactly one trigger_out pulse 2 cycles later, with trace_out=32'hDEADBEEF and src_id=2.
REQ-033 Round-robin: all 5 sources strobe once in the same cycle with data i -> 5 consecutive trigger_out pulses with src_id 0,1,2,3,4 and no gaps.
REQ-034 Overflow: out_ready=0; source 1 strobes 6 times with DEPTH=4 -> overflow=5'b00010 and drop_cnt=2; after raising out_ready, exactly the first 4 words appear in order.
REQ-035 Full with simultaneous pop: FIFO 0 full, out_ready=1, source 0 strobes every cycle -> no drops, drop_cnt stays 0, and output is continuous.
REQ-036 Clear and saturate: preload drop_cnt to 16'hFFFE, then cause 3 drops -> drop_cnt=16'hFFFF; pulse clear_ovf with no drop -> overflow=0 and drop_cnt=0.
REQ-037 Reset mid-burst: assert reset while 3 words are buffered -> trigger_out=0 immediately, and no stale words appear after release.

Source files
------------

// File: rtl/trace_arbiter_if.sv
// Trace arbiter port bundle: per-source trace inputs, arbitrated output and drop status.
// slave modport faces the arbiter, master modport faces the sources/trace buffer side.
interface trace_arbiter_if #(
    parameter int NSRC = 5,
    parameter int Fpay = 32
);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [NSRC*Fpay-1:0] trace_all;
    logic [NSRC-1:0]      trigger_all;
    logic                 out_ready;
    logic                 clear_ovf;
    logic [Fpay-1:0]      trace_out;
    logic                 trigger_out;
    logic [SW-1:0]        src_id;
    logic [NSRC-1:0]      overflow;
    logic [15:0]          drop_cnt;

    modport slave (
        input  trace_all, trigger_all, out_ready, clear_ovf,
        output trace_out, trigger_out, src_id, overflow, drop_cnt
    );

    modport master (
        output trace_all, trigger_all, out_ready, clear_ovf,
        input  trace_out, trigger_out, src_id, overflow, drop_cnt
    );
endinterface

// File: rtl/trace_arbiter.sv
// Round-robin trace arbiter with per-source FIFOs and sticky drop accounting.
// Latency 2 cycles strobe->trigger_out; out_ready=0 stalls all pops, full FIFOs drop new words.
module trace_arbiter #(
    parameter int NSRC  = 5,
    parameter int Fpay  = 32,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    trace_arbiter_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int CW = $clog2(NSRC + 1);

    logic [Fpay-1:0] r_mem [NSRC][DEPTH];
    logic [AW-1:0]   r_wptr [NSRC];
    logic [AW-1:0]   r_rptr [NSRC];
    logic [AW:0]     r_cnt  [NSRC];
    logic [SW-1:0]   r_rr;

    logic [Fpay-1:0] r_trace_out;
    logic            r_trigger_out;
    logic [SW-1:0]   r_src_id;
    logic [NSRC-1:0] r_overflow;
    logic [15:0]     r_drop_cnt;

    logic [NSRC-1:0] w_nonempty;
    logic [NSRC-1:0] w_full;
    logic [NSRC-1:0] w_push;
    logic [NSRC-1:0] w_pop;
    logic [NSRC-1:0] w_drop;
    logic            w_gnt_vld;
    logic [SW-1:0]   w_gnt_idx;
    logic [SW-1:0]   w_rr_nxt;
    logic [Fpay-1:0] w_head;
    logic [CW-1:0]   w_ndrop;
    logic [16:0]     w_drop_sum;
    logic [15:0]     w_drop_sat;

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            w_nonempty[i] = (r_cnt[i] != '0);
            w_full[i]     = (r_cnt[i] == (AW+1)'(DEPTH));
        end
    end

    // Scan from the priority pointer; first non-empty FIFO wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int k = 0; k < NSRC; k++) begin
            idx = int'(r_rr) + k;
            if (idx >= NSRC) idx = idx - NSRC;
            if (bus.out_ready && !w_gnt_vld && w_nonempty[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = SW'(idx);
            end
        end
    end

    assign w_rr_nxt = (w_gnt_idx == SW'(NSRC - 1)) ? '0 : w_gnt_idx + SW'(1);
    assign w_head   = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

    // A full FIFO still accepts a write when it is popped in the same cycle.
    always_comb begin
        w_ndrop = '0;
        for (int i = 0; i < NSRC; i++) begin
            w_pop[i]  = w_gnt_vld && (w_gnt_idx == SW'(i));
            w_push[i] = bus.trigger_all[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = bus.trigger_all[i] && w_full[i] && !w_pop[i];
            w_ndrop   = w_ndrop + CW'(w_drop[i]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_ndrop);
    assign w_drop_sat = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NSRC; i++) begin
            if (w_push[i]) r_mem[i][r_wptr[i]] <= bus.trace_all[i*Fpay +: Fpay];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSRC; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (w_push[i]) r_wptr[i] <= r_wptr[i] + AW'(1);
                if (w_pop[i])  r_rptr[i] <= r_rptr[i] + AW'(1);
                case ({w_push[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + (AW+1)'(1);
                    2'b01:   r_cnt[i] <= r_cnt[i] - (AW+1)'(1);
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr          <= '0;
            r_trigger_out <= 1'b0;
            r_trace_out   <= '0;
            r_src_id      <= '0;
        end else begin
            r_trigger_out <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr        <= w_rr_nxt;
                r_trace_out <= w_head;
                r_src_id    <= w_gnt_idx;
            end
        end
    end

    // Clear loses to a same-cycle drop: the new drops become the fresh status.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= '0;
            r_drop_cnt <= '0;
        end else if (bus.clear_ovf) begin
            r_overflow <= w_drop;
            r_drop_cnt <= 16'(w_ndrop);
        end else begin
            r_overflow <= r_overflow | w_drop;
            r_drop_cnt <= w_drop_sat;
        end
    end

    assign bus.trace_out   = r_trace_out;
    assign bus.trigger_out = r_trigger_out;
    assign bus.src_id      = r_src_id;
    assign bus.overflow    = r_overflow;
    assign bus.drop_cnt    = r_drop_cnt;
endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: latency, round-robin, overflow, full+pop, saturation, reset.
module tb_trace_arbiter;
    localparam int NSRC  = 5;
    localparam int Fpay  = 32;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    trace_arbiter_if #(.NSRC(NSRC), .Fpay(Fpay)) bus ();

    trace_arbiter #(.NSRC(NSRC), .Fpay(Fpay), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_word(input int i, input logic [31:0] val);
        bus.trace_all[i*Fpay +: Fpay] = val;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        bus.trace_all   = '0;
        bus.trigger_all = '0;
        bus.out_ready   = 1'b0;
        bus.clear_ovf   = 1'b0;
        #12;
        chk("rst_trig", 64'(bus.trigger_out), 64'd0);
        chk("rst_data", 64'(bus.trace_out), 64'd0);
        chk("rst_src", 64'(bus.src_id), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_drop", 64'(bus.drop_cnt), 64'd0);
        tick();
        reset = 1'b1;

        // Single word, 2-cycle latency
        bus.out_ready = 1'b1;
        set_word(2, 32'hDEADBEEF);
        bus.trigger_all = 5'b00100;
        tick();
        bus.trigger_all = '0;
        chk("single_early", 64'(bus.trigger_out), 64'd0);
        tick();
        chk("single_trig", 64'(bus.trigger_out), 64'd1);
        chk("single_data", 64'(bus.trace_out), 64'hDEADBEEF);
        chk("single_src", 64'(bus.src_id), 64'd2);
        tick();
        chk("single_once", 64'(bus.trigger_out), 64'd0);
        chk("single_hold", 64'(bus.trace_out), 64'hDEADBEEF);

        // Round-robin from a fresh pointer
        do_reset();
        bus.out_ready = 1'b1;
        for (int i = 0; i < NSRC; i++) set_word(i, 32'h100 + i);
        bus.trigger_all = 5'b11111;
        tick();
        bus.trigger_all = '0;
        tick();
        for (int i = 0; i < NSRC; i++) begin
            chk("rr_trig", 64'(bus.trigger_out), 64'd1);
            chk("rr_src", 64'(bus.src_id), 64'(i));
            chk("rr_data", 64'(bus.trace_out), 64'(32'h100 + i));
            tick();
        end
        chk("rr_end", 64'(bus.trigger_out), 64'd0);

        // Overflow on source 1 with out_ready low
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            set_word(1, 32'hA0 + k);
            bus.trigger_all = 5'b00010;
            tick();
        end
        bus.trigger_all = '0;
        chk("ovf_flag", 64'(bus.overflow), 64'b00010);
        chk("ovf_cnt", 64'(bus.drop_cnt), 64'd2);
        chk("ovf_stall", 64'(bus.trigger_out), 64'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ovf_trig", 64'(bus.trigger_out), 64'd1);
            chk("ovf_src", 64'(bus.src_id), 64'd1);
            chk("ovf_data", 64'(bus.trace_out), 64'(32'hA0 + k));
        end
        tick();
        chk("ovf_nomore", 64'(bus.trigger_out), 64'd0);
        chk("ovf_sticky", 64'(bus.overflow), 64'b00010);

        // Clear status, then full FIFO 0 written while popped every cycle
        bus.clear_ovf = 1'b1;
        tick();
        bus.clear_ovf = 1'b0;
        chk("clr_flag", 64'(bus.overflow), 64'd0);
        chk("clr_cnt", 64'(bus.drop_cnt), 64'd0);
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_word(0, 32'hB0 + k);
            bus.trigger_all = 5'b00001;
            tick();
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            set_word(0, 32'hB4 + k);
            bus.trigger_all = 5'b00001;
            tick();
            chk("fp_trig", 64'(bus.trigger_out), 64'd1);
            chk("fp_data", 64'(bus.trace_out), 64'(32'hB0 + k));
        end
        bus.trigger_all = '0;
        for (int k = 6; k < 10; k++) begin
            tick();
            chk("fp_drain_trig", 64'(bus.trigger_out), 64'd1);
            chk("fp_drain_data", 64'(bus.trace_out), 64'(32'hB0 + k));
        end
        tick();
        chk("fp_end", 64'(bus.trigger_out), 64'd0);
        chk("fp_nodrop", 64'(bus.drop_cnt), 64'd0);
        chk("fp_noovf", 64'(bus.overflow), 64'd0);

        // Drive drop_cnt to 16'hFFFE, then saturate
        do_reset();
        bus.out_ready = 1'b0;
        bus.trigger_all = 5'b11111;
        for (int k = 0; k < DEPTH; k++) tick();
        chk("sat_fill", 64'(bus.drop_cnt), 64'd0);
        for (int k = 0; k < 13106; k++) tick();
        bus.trigger_all = 5'b01111;
        tick();
        chk("sat_fffe", 64'(bus.drop_cnt), 64'hFFFE);
        bus.trigger_all = 5'b00111;
        tick();
        bus.trigger_all = '0;
        chk("sat_ffff", 64'(bus.drop_cnt), 64'hFFFF);
        chk("sat_ovf", 64'(bus.overflow), 64'b11111);
        tick();
        chk("sat_hold", 64'(bus.drop_cnt), 64'hFFFF);
        bus.clear_ovf = 1'b1;
        tick();
        chk("sat_clr_cnt", 64'(bus.drop_cnt), 64'd0);
        chk("sat_clr_ovf", 64'(bus.overflow), 64'd0);
        bus.trigger_all = 5'b00010;
        tick();
        bus.trigger_all = '0;
        bus.clear_ovf = 1'b0;
        chk("clrwin_ovf", 64'(bus.overflow), 64'b00010);
        chk("clrwin_cnt", 64'(bus.drop_cnt), 64'd1);

        // Reset while words are buffered
        do_reset();
        bus.out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_word(3, 32'hC0 + k);
            bus.trigger_all = 5'b01000;
            tick();
        end
        bus.trigger_all = '0;
        bus.out_ready = 1'b1;
        tick();
        chk("mid_pre_trig", 64'(bus.trigger_out), 64'd1);
        chk("mid_pre_data", 64'(bus.trace_out), 64'hC0);
        reset = 1'b0;
        #1;
        chk("mid_async_trig", 64'(bus.trigger_out), 64'd0);
        chk("mid_async_data", 64'(bus.trace_out), 64'd0);
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("mid_stale", 64'(bus.trigger_out), 64'd0);
        end
        set_word(4, 32'hE0);
        bus.trigger_all = 5'b10000;
        tick();
        bus.trigger_all = '0;
        tick();
        chk("mid_new_trig", 64'(bus.trigger_out), 64'd1);
        chk("mid_new_data", 64'(bus.trace_out), 64'hE0);
        chk("mid_new_src", 64'(bus.src_id), 64'd4);
        tick();
        chk("mid_new_once", 64'(bus.trigger_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
